// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 keystream/decrypt engine.
// Holds the FSM state encoding and the plaintext character-class check.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC,
    ST_RDI,
    ST_CPI,
    ST_RDJ,
    ST_CPJ,
    ST_WRI,
    ST_WRJ,
    ST_RDF,
    ST_CPF,
    ST_CHK,
    ST_FIN
  } state_e;

  localparam int CHECK_NONE  = 0;
  localparam int CHECK_LOWER = 1;
  localparam int CHECK_PRINT = 2;

  function automatic logic char_ok(input logic [7:0] b,
                                   input int mode);
    logic ok;
    case (mode)
      CHECK_LOWER:
        ok = (b >= 8'h61 && b <= 8'h7a) || b == 8'h20;
      CHECK_PRINT:
        ok = b >= 8'h20 && b <= 8'h7e;
      default:
        ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rc4_prga_decoder.sv
// RC4 PRGA engine: walks S-RAM, XORs keystream with the message ROM,
// writes plaintext and aborts on the first out-of-class byte.
module rc4_prga_decoder
  import rc4_pkg::*;
#(
  parameter int MSG_LEN    = 32,
  parameter int K_W        = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
  parameter int CHECK_MODE = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  output logic [7:0]     s_addr,
  output logic [7:0]     s_wdata,
  output logic           s_we,
  input  logic [7:0]     s_rdata,
  output logic [K_W-1:0] rom_addr,
  input  logic [7:0]     rom_rdata,
  output logic [K_W-1:0] dec_addr,
  output logic [7:0]     dec_wdata,
  output logic           dec_we,
  output logic           busy,
  output logic           done,
  output logic           bad_key,
  output logic [K_W-1:0] bad_index
);

  localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

  state_e         state_q, state_d;
  logic [7:0]     i_q, i_d;
  logic [7:0]     j_q, j_d;
  logic [7:0]     si_q, si_d;
  logic [7:0]     sj_q, sj_d;
  logic [7:0]     f_q, f_d;
  logic [7:0]     enc_q, enc_d;
  logic [K_W-1:0] k_q, k_d;
  logic           bad_key_q, bad_key_d;
  logic [K_W-1:0] bad_index_q, bad_index_d;
  logic [7:0]     p;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      f_q         <= '0;
      enc_q       <= '0;
      k_q         <= '0;
      bad_key_q   <= 1'b0;
      bad_index_q <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      f_q         <= f_d;
      enc_q       <= enc_d;
      k_q         <= k_d;
      bad_key_q   <= bad_key_d;
      bad_index_q <= bad_index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    f_d         = f_q;
    enc_d       = enc_q;
    k_d         = k_q;
    bad_key_d   = bad_key_q;
    bad_index_d = bad_index_q;
    s_addr      = '0;
    s_wdata     = '0;
    s_we        = 1'b0;
    rom_addr    = '0;
    dec_addr    = '0;
    dec_wdata   = '0;
    dec_we      = 1'b0;
    done        = 1'b0;
    p           = f_q ^ enc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d         = '0;
          j_d         = '0;
          k_d         = '0;
          bad_key_d   = 1'b0;
          bad_index_d = '0;
          state_d     = ST_INC;
        end
      end
      ST_INC: begin
        i_d     = i_q + 8'd1;
        state_d = ST_RDI;
      end
      ST_RDI: begin
        s_addr  = i_q;
        state_d = ST_CPI;
      end
      ST_CPI: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata;
        state_d = ST_RDJ;
      end
      ST_RDJ: begin
        s_addr  = j_q;
        state_d = ST_CPJ;
      end
      ST_CPJ: begin
        sj_d    = s_rdata;
        state_d = ST_WRI;
      end
      ST_WRI: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_we    = 1'b1;
        state_d = ST_WRJ;
      end
      // i == j lands here with si == sj, so the swap is a no-op
      ST_WRJ: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_we    = 1'b1;
        state_d = ST_RDF;
      end
      ST_RDF: begin
        s_addr   = si_q + sj_q;
        rom_addr = k_q;
        state_d  = ST_CPF;
      end
      ST_CPF: begin
        f_d     = s_rdata;
        enc_d   = rom_rdata;
        state_d = ST_CHK;
      end
      ST_CHK: begin
        if (char_ok(p, CHECK_MODE)) begin
          dec_we    = 1'b1;
          dec_addr  = k_q;
          dec_wdata = p;
          if (k_q == K_LAST) begin
            state_d = ST_FIN;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_INC;
          end
        end else begin
          bad_key_d   = 1'b1;
          bad_index_d = k_q;
          state_d     = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = state_q != ST_IDLE;
  assign bad_key   = bad_key_q;
  assign bad_index = bad_index_q;

endmodule
